traffic_signal_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 13 +
 rtl/traffic_signal_ctrl_tick_gen.sv | 34 +++
 rtl/traffic_signal_ctrl.sv | 73 +++++++
 tb/tb_traffic_signal_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types, widths and approach constants for the intersection phase sequencer
package traffic_pkg;
  typedef enum logic {GREEN, CLEAR} state_t;
  localparam int POS_W = 2;
  localparam int SEC_W = 4;
  localparam logic [POS_W-1:0] POS_N = 2'd0;
  localparam logic [POS_W-1:0] POS_E = 2'd1;
  localparam logic [POS_W-1:0] POS_S = 2'd2;
  localparam logic [POS_W-1:0] POS_W_DIR = 2'd3;
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] p);
    return p == POS_N ? POS_E : p == POS_E ? POS_S : p == POS_S ? POS_W_DIR : POS_N;
  endfunction
endpackage

// File: rtl/traffic_signal_ctrl_tick_gen.sv
// tick_gen: free-running quarter-second prescaler, 4 Hz flash clock and Run-gated second tick
module tick_gen #(
  parameter int CYC_PER_QTR = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic clk_4hz,
  output logic qtr_tick,
  output logic sec_tick
);
  localparam int CW = $clog2(CYC_PER_QTR);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] qcnt_q, qcnt_d;
  logic clk_4hz_q, clk_4hz_d;
  assign qtr_tick = cnt_q == CW'(CYC_PER_QTR - 1);
  assign sec_tick = qtr_tick & (qcnt_q == 2'd3) & run;
  assign clk_4hz = clk_4hz_q;
  always_comb begin
    cnt_d = qtr_tick ? '0 : cnt_q + 1'b1;
    clk_4hz_d = qtr_tick ? 1'b0 : (cnt_q == CW'(CYC_PER_QTR / 2 - 1)) ? 1'b1 : clk_4hz_q;
    qcnt_d = (qtr_tick & run) ? qcnt_q + 2'd1 : qcnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      qcnt_q <= '0;
      clk_4hz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      qcnt_q <= qcnt_d;
      clk_4hz_q <= clk_4hz_d;
    end
endmodule

// File: rtl/traffic_signal_ctrl.sv
// traffic_signal_ctrl: GREEN/CLEAR phase sequencer rotating the green approach with seconds countdown.
// PHASE_SKIP_EN adds the Skip_req button that cuts the current green short.
module traffic_signal_ctrl
  import traffic_pkg::*;
#(
  parameter int CYC_PER_QTR = 12_500_000,
  parameter int GREEN_SEC = 10,
  parameter int CLEAR_SEC = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Run,
`ifdef PHASE_SKIP_EN
  input  logic Skip_req,
`endif
  output logic [POS_W-1:0] Signal_Pos,
  output logic light_out_time,
  output logic CLK_4Hz,
  output logic [SEC_W-1:0] sec_left,
  output logic Phase_chg
);
  state_t state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic light_q, light_d, phase_q, phase_d;
  logic qtr_tick, sec_tick, skip, adv;
  tick_gen #(.CYC_PER_QTR(CYC_PER_QTR)) u_tick (
    .clk(CLK),
    .rst_n(RST_n),
    .run(Run),
    .clk_4hz(CLK_4Hz),
    .qtr_tick(qtr_tick),
    .sec_tick(sec_tick)
  );
`ifdef PHASE_SKIP_EN
  logic [2:0] sync_q;
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) sync_q <= '0;
    else sync_q <= {sync_q[1:0], Skip_req};
  assign skip = sync_q[1] & ~sync_q[2];
`else
  assign skip = 1'b0;
`endif
  assign adv = sec_tick & (sec_q == SEC_W'(1));
  always_comb begin
    state_d = adv ? (state_q == GREEN ? CLEAR : GREEN) : state_q;
    pos_d = (adv && state_q == CLEAR) ? next_pos(pos_q) : pos_q;
    light_d = state_d == CLEAR;
    phase_d = adv && state_q == CLEAR;
    // a skip outranks a plain decrement but never the end-of-interval transition
    sec_d = adv ? (state_q == GREEN ? SEC_W'(CLEAR_SEC) : SEC_W'(GREEN_SEC))
          : (skip && state_q == GREEN && sec_q > SEC_W'(1)) ? SEC_W'(1)
          : sec_tick ? sec_q - 1'b1 : sec_q;
  end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      state_q <= GREEN;
      pos_q <= POS_N;
      sec_q <= SEC_W'(GREEN_SEC);
      light_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      sec_q <= sec_d;
      light_q <= light_d;
      phase_q <= phase_d;
    end
  assign Signal_Pos = pos_q;
  assign light_out_time = light_q;
  assign sec_left = sec_q;
  assign Phase_chg = phase_q;
endmodule

// File: tb/tb_traffic_signal_ctrl.sv
// tb_traffic_signal_ctrl: directed self-checking bench for traffic_signal_ctrl (CYC_PER_QTR=4, GREEN_SEC=3, CLEAR_SEC=1)
module tb_traffic_signal_ctrl;
  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic Run = 1'b1;
  logic Skip_req = 1'b0;
  logic [1:0] Signal_Pos;
  logic light_out_time, CLK_4Hz, Phase_chg;
  logic [3:0] sec_left;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always #5 CLK = ~CLK;
  traffic_signal_ctrl #(.CYC_PER_QTR(4), .GREEN_SEC(3), .CLEAR_SEC(1)) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .Run(Run),
`ifdef PHASE_SKIP_EN
    .Skip_req(Skip_req),
`endif
    .Signal_Pos(Signal_Pos),
    .light_out_time(light_out_time),
    .CLK_4Hz(CLK_4Hz),
    .sec_left(sec_left),
    .Phase_chg(Phase_chg)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) @(posedge CLK);
    cyc += n;
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pos"}, Signal_Pos, 0);
    chk({tag, "_light"}, light_out_time, 0);
    chk({tag, "_sec"}, sec_left, 3);
    chk({tag, "_clk4"}, CLK_4Hz, 0);
    chk({tag, "_phase"}, Phase_chg, 0);
  endtask
  task automatic release_reset();
    @(negedge CLK);
    RST_n = 1'b1;
    cyc = 0;
    #1;
  endtask
  initial begin
    int m;
    int pulses;
    logic pl;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("in_reset");
    release_reset();
    chk_reset_vals("cycle0");
    pulses = 0;
    pl = light_out_time;
    for (int i = 1; i <= 256; i++) begin
      adv(1);
      m = cyc % 64;
      chk("rot_pos", Signal_Pos, (cyc / 64) % 4);
      chk("rot_light", light_out_time, m >= 48);
      chk("rot_sec", sec_left, m < 48 ? 3 - m / 16 : 1);
      chk("rot_clk4", CLK_4Hz, (cyc % 4) >= 2);
      chk("rot_phase", Phase_chg, m == 0);
      if (Phase_chg) begin
        pulses++;
        chk("phase_on_light_fall", {pl, light_out_time}, 2'b10);
      end
      pl = light_out_time;
    end
    chk("phase_pulse_count", pulses, 4);
    adv(20);
    chk("pre_freeze_sec", sec_left, 2);
    Run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      adv(1);
      chk("freeze_clk4", CLK_4Hz, (cyc % 4) >= 2);
      chk("freeze_sec", sec_left, 2);
      chk("freeze_pos", Signal_Pos, 0);
      chk("freeze_light", light_out_time, 0);
    end
    Run = 1'b1;
    adv(12);
    chk("resume_sec1", sec_left, 1);
    adv(15);
    chk("resume_still_green", light_out_time, 0);
    adv(1);
    chk("resume_clear_entry", light_out_time, 1);
    chk("resume_clear_sec", sec_left, 1);
    adv(16);
    chk("resume_green_pos1", Signal_Pos, 1);
    chk("resume_phase", Phase_chg, 1);
    adv(50);
    chk("pre_rst_light", light_out_time, 1);
    chk("pre_rst_pos", Signal_Pos, 1);
    chk("pre_rst_clk4", CLK_4Hz, 1);
    RST_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    release_reset();
    chk_reset_vals("rerelease");
    adv(16);
    chk("rerelease_sec2", sec_left, 2);
`ifdef PHASE_SKIP_EN
    release_reset();
    RST_n = 1'b0;
    #1;
    release_reset();
    adv(2);
    chk("skip_pre_sec", sec_left, 3);
    Skip_req = 1'b1;
    adv(1);
    Skip_req = 1'b0;
    adv(3);
    chk("skip_sec1", sec_left, 1);
    chk("skip_still_green", light_out_time, 0);
    adv(10);
    chk("skip_clear_entry", light_out_time, 1);
    Skip_req = 1'b1;
    adv(1);
    Skip_req = 1'b0;
    adv(5);
    chk("skip_in_clear_light", light_out_time, 1);
    chk("skip_in_clear_sec", sec_left, 1);
    adv(10);
    chk("skip_next_green_pos", Signal_Pos, 1);
    chk("skip_next_green_sec", sec_left, 3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
